// File: rtl/irq_defs_pkg.sv
// Shared definitions for the interrupt controller: register offsets, field positions
// and source-count limits.
package irq_defs;

  localparam int unsigned N_SRC_MAX   = 8;
  localparam int unsigned VEC_ACT_BIT = 7;

  typedef enum logic [1:0] {
    IRQ_PEND = 2'd0,
    IRQ_MASK = 2'd1,
    IRQ_MODE = 2'd2,
    IRQ_VEC  = 2'd3
  } irq_reg_e;

  function automatic logic [N_SRC_MAX-1:0] onehot8(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins 8-to-3 priority encoder; bit 0 has the highest priority.
module irq_prio_enc
  import irq_defs::*;
(
  input  logic [N_SRC_MAX-1:0] req_i,
  output logic [2:0]           idx_o,
  output logic                 valid_o
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N_SRC_MAX - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches edge sources, passes level sources through, masks and
// prioritises them and drives one registered interrupt line to the CPU.
module irq_ctrl
  import irq_defs::*;
#(
  parameter int unsigned N_SRC    = 8,
  parameter logic [7:0]  MODE_RST = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       AD,
  input  logic [7:0]       DI,
  output logic [7:0]       DO,
  input  logic             rw,
  input  logic             cs,
  input  logic [N_SRC-1:0] src,
  output logic             intr
);

  localparam logic [7:0] SrcMask = 8'((9'd1 << N_SRC) - 9'd1);

  logic [7:0] src_ext, src_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] mode_q, mode_d;
  logic       intr_q, intr_d;
  logic [7:0] pend_vec, act_vec, edge_set, clr;
  logic [2:0] idx;
  logic       act;
  logic       wr_en;
  irq_reg_e   reg_sel;

  always_comb begin
    src_ext            = '0;
    src_ext[N_SRC-1:0] = src;
  end

  assign reg_sel = irq_reg_e'(AD);
  assign wr_en   = cs & ~rw;

  // Level bits read the live request; they are forced to zero while reset is held.
  assign pend_vec = ((pend_q & mode_q) | (src_ext & ~mode_q & {8{rst}})) & SrcMask;
  assign act_vec  = pend_vec & mask_q;

  irq_prio_enc u_prio_enc (
    .req_i   (act_vec),
    .idx_o   (idx),
    .valid_o (act)
  );

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    clr    = '0;
    if (wr_en) begin
      unique case (reg_sel)
        IRQ_PEND: clr    = DI;
        IRQ_MASK: mask_d = DI & SrcMask;
        IRQ_MODE: mode_d = DI & SrcMask;
        IRQ_VEC:  if (act) clr = onehot8(idx);
        default:  ;
      endcase
    end
    // Edges use the pre-write mode; set beats clear; a bit leaving edge mode is dropped.
    edge_set = src_ext & ~src_q & mode_q;
    pend_d   = ((pend_q & ~clr) | edge_set) & mode_d;
    intr_d   = act;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      mode_q <= MODE_RST & SrcMask;
      intr_q <= 1'b0;
    end else begin
      src_q  <= src_ext;
      pend_q <= pend_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      intr_q <= intr_d;
    end
  end

  always_comb begin
    DO = '0;
    unique case (reg_sel)
      IRQ_PEND: DO = pend_vec;
      IRQ_MASK: DO = mask_q;
      IRQ_MODE: DO = mode_q;
      IRQ_VEC: begin
        if (act) begin
          DO[VEC_ACT_BIT] = 1'b1;
          DO[2:0]         = idx;
        end
      end
      default: DO = '0;
    endcase
  end

  assign intr = intr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenarios followed by randomized traffic checked against a per-source
// behavioural model of the interrupt controller.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic [7:0] src;
  logic       intr;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-source latch, enable, mode and previous request level.
  logic [7:0] m_lat, m_mask, m_mode, m_prev;
  logic       m_intr;

  irq_ctrl #(
    .N_SRC    (8),
    .MODE_RST (8'h00)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .AD   (AD),
    .DI   (DI),
    .DO   (DO),
    .rw   (rw),
    .cs   (cs),
    .src  (src),
    .intr (intr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_view();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      if (!rst) v[i] = 1'b0;
      else if (m_mode[i]) v[i] = m_lat[i];
      else v[i] = src[i];
    end
    return v;
  endfunction

  function automatic int m_first(input logic [7:0] a);
    for (int i = 0; i < 8; i++) if (a[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    int k;
    case (a)
      2'd0:    return m_view();
      2'd1:    return m_mask;
      2'd2:    return m_mode;
      default: begin
        k = m_first(m_view() & m_mask);
        return (k < 0) ? 8'h00 : 8'(8'h80 + k);
      end
    endcase
  endfunction

  task automatic m_reset();
    m_lat  = '0;
    m_mask = '0;
    m_mode = 8'h00;
    m_prev = '0;
    m_intr = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, updating the model from the inputs held during this cycle.
  task automatic step();
    logic [7:0] nl, nmask, nmode;
    logic       keep, wr;
    int         k;
    if (!rst) begin
      @(posedge clk);
      #1;
      m_reset();
      return;
    end
    nmask = m_mask;
    nmode = m_mode;
    k     = m_first(m_view() & m_mask);
    wr    = cs && !rw;
    if (wr && AD == 2'd1) nmask = DI;
    if (wr && AD == 2'd2) nmode = DI;
    for (int i = 0; i < 8; i++) begin
      keep = m_lat[i];
      if (wr && AD == 2'd0 && DI[i]) keep = 1'b0;
      if (wr && AD == 2'd3 && k == i) keep = 1'b0;
      if (m_mode[i] && src[i] && !m_prev[i]) keep = 1'b1;
      if (!nmode[i]) keep = 1'b0;
      nl[i] = keep;
    end
    @(posedge clk);
    #1;
    m_lat  = nl;
    m_mask = nmask;
    m_mode = nmode;
    m_intr = (k >= 0);
    m_prev = src;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    AD = a;
    DI = d;
    rw = 1'b0;
    cs = 1'b1;
    step();
    cs = 1'b0;
    rw = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    AD = a;
    cs = 1'b1;
    rw = 1'b1;
    #1;
    check(tag, DO, exp);
    cs = 1'b0;
  endtask

  task automatic intr_chk(input string tag, input logic exp);
    check(tag, {7'b0, intr}, {7'b0, exp});
  endtask

  initial begin
    rst = 1'b0;
    src = 8'hFF;
    cs  = 1'b0;
    rw  = 1'b1;
    AD  = 2'd0;
    DI  = 8'h00;
    m_reset();

    // 1: reset hold, then level passthrough with everything masked
    repeat (3) step();
    intr_chk("rst_intr", 1'b0);
    rd_chk("rst_pend", 2'd0, 8'h00);
    rd_chk("rst_mask", 2'd1, 8'h00);
    rst = 1'b1;
    step();
    rd_chk("lvl_pend_ff", 2'd0, 8'hFF);
    rd_chk("lvl_vec_idle", 2'd3, 8'h00);
    intr_chk("lvl_intr_masked", 1'b0);

    // 2: level path
    src = 8'h04;
    wr_reg(2'd1, 8'h04);
    rd_chk("lvl_vec2", 2'd3, 8'h82);
    intr_chk("lvl_intr_lag", 1'b0);
    step();
    intr_chk("lvl_intr_up", 1'b1);
    src = 8'h00;
    rd_chk("lvl_vec_drop", 2'd3, 8'h00);
    step();
    intr_chk("lvl_intr_down", 1'b0);

    // 3: edge latch and W1C
    wr_reg(2'd2, 8'h01);
    wr_reg(2'd1, 8'h01);
    src = 8'h01;
    step();
    src = 8'h00;
    step();
    rd_chk("edge_pend", 2'd0, 8'h01);
    intr_chk("edge_intr", 1'b1);
    step();
    rd_chk("edge_persist", 2'd0, 8'h01);
    wr_reg(2'd0, 8'h01);
    rd_chk("edge_w1c", 2'd0, 8'h00);
    step();
    intr_chk("edge_intr_clr", 1'b0);

    // 4: priority and EOI
    wr_reg(2'd2, 8'hFF);
    wr_reg(2'd1, 8'hFF);
    src = 8'h22;
    step();
    src = 8'h00;
    rd_chk("prio_vec1", 2'd3, 8'h81);
    wr_reg(2'd3, 8'h00);
    rd_chk("eoi1_pend", 2'd0, 8'h20);
    rd_chk("eoi1_vec", 2'd3, 8'h85);
    wr_reg(2'd3, 8'h5A);
    rd_chk("eoi2_pend", 2'd0, 8'h00);
    step();
    intr_chk("eoi2_intr", 1'b0);

    // 5: set beats clear in the same cycle
    src = 8'h08;
    wr_reg(2'd0, 8'h08);
    rd_chk("collide_pend", 2'd0, 8'h08);
    step();
    intr_chk("collide_intr", 1'b1);

    // 6: asynchronous reset between clock edges
    wr_reg(2'd0, 8'hFF);
    src = 8'h18;
    step();
    step();
    rd_chk("pre_arst_pend", 2'd0, 8'h10);
    intr_chk("pre_arst_intr", 1'b1);
    rst = 1'b0;
    #1;
    intr_chk("arst_intr", 1'b0);
    rd_chk("arst_pend", 2'd0, 8'h00);
    m_reset();
    rst = 1'b1;
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int op;
      src = 8'($urandom);
      op  = int'($urandom_range(0, 3));
      AD  = 2'($urandom);
      DI  = 8'($urandom);
      case (op)
        0, 1: begin cs = 1'b1; rw = 1'b0; end
        2:    begin cs = 1'b1; rw = 1'b1; end
        default: begin cs = 1'b0; rw = 1'($urandom); end
      endcase
      #1;
      check("rnd_do", DO, m_read(AD));
      check("rnd_intr", {7'b0, intr}, {7'b0, m_intr});
      step();
      cs = 1'b0;
      rw = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller between the peripherals (timer, memory-map fault, UART, GPIO) and the single CPU `intr` input.
- Latches, masks and prioritises up to 8 request lines and drives one registered interrupt output.
- Exposes a 4-byte register window on the CPU bus, using the same AD/DI/DO/rw/cs style as the timer and gpio.
- Mapped into a free DS slot in the top level.

Parameters:
- N_SRC, 8, number of request inputs (1..8); unused bits read 0 and never pend.
- MODE_RST, 8'h00, reset value of MODE (1 = rising-edge source, 0 = level source).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low; all registers cleared while low.
- AD  in  2  register select.
- DI  in  8  write data from CPU.
- DO  out  8  read data, combinational from AD and current registers.
- rw  in  1  1 = read, 0 = write.
- cs  in  1  chip select; a write takes effect on the clk edge where cs=1 and rw=0.
- src  in  N_SRC  interrupt requests, synchronous to clk, active-high.
- intr  out  1  interrupt to CPU, registered.

Behaviour:
- Register map:
  - AD=0 PEND: read gives the pending vector. Write is write-1-to-clear, edge sources only.
  - AD=1 MASK: R/W, 1 = enabled. Reset 8'h00.
  - AD=2 MODE: R/W. Reset MODE_RST.
  - AD=3 VEC: read gives {act, 4'b0000, idx[2:0]}. Any write is EOI.
- Edge source i (MODE[i]=1):
  - src_q holds src from the previous cycle (reset 0).
  - pend[i] is set on the cycle where src[i]=1 and src_q[i]=0.
  - It stays set until cleared by a PEND W1C or by EOI.
- Level source i (MODE[i]=0):
  - PEND[i] reads src[i] directly; nothing is latched.
  - W1C and EOI have no effect on it.
- Set/clear collision: if a new edge and a clear for the same bit land in the same cycle, the set wins and the bit stays 1.
- Mode change: writing MODE from 1 to 0 discards the latched pend bit. Writing 0 to 1 starts with the bit clear.
- Active vector: act_vec = PEND & MASK.
- Priority: idx is the lowest set index of act_vec (bit 0 highest priority); act = |act_vec. When act=0, VEC reads 8'h00.
- EOI: a write to AD=3 clears pend[idx] if that source is edge mode and act=1. idx is sampled from the pre-write state. Otherwise the write is a no-op.
- intr:
  - Registered: intr <= |act_vec.
  - Rises one clk after a pending and enabled condition appears.
  - Falls one clk after it disappears.
- Reads: DO follows AD with zero latency and ignores cs. The top-level mux gates it by cs.
- Write/edge overlap: a write to MASK or MODE in the same cycle as an edge applies to the state used in the next cycle. The edge is still latched if MODE[i] was 1 before the write.
- Reset while low: PEND, MASK=0, MODE=MODE_RST, src_q=0, intr=0, DO reflects those values.
- Reset release: src_q=0, so a source already high at release produces an edge in the first active cycle. This is intended, so that pre-reset requests are not lost.
- Write conditions: no writes occur when cs=0. Writes to AD=0..2 with rw=1 are ignored.

Decomposition:
- Shared package/include irq_defs:
  - register offsets IRQ_PEND=0, IRQ_MASK=1, IRQ_MODE=2, IRQ_VEC=3
  - VEC_ACT_BIT=7
  - N_SRC_MAX=8
- Sub-module irq_prio_enc: combinational 8-to-3 lowest-index priority encoder with valid output. It is instantiated once and shared by the VEC read and the EOI clear.

Test Plan:
1. Reset → clear → level passthrough:
   - Hold rst=0 with src=8'hFF → intr=0, PEND/MASK read 8'h00.
   - Release, MODE=00, MASK=00 → PEND reads 8'hFF, VEC reads 8'h00, intr stays 0.
2. Level path:
   - MASK=8'h04, src[2]=1 → intr=1 one clk later, VEC=8'h82.
   - Drop src[2] → intr=0 one clk later, VEC=8'h00.
3. Edge latch:
   - MODE=8'h01, MASK=8'h01, pulse src[0] for 1 clk → PEND=8'h01 persists after the pulse, intr=1.
   - Write PEND=8'h01 → PEND=8'h00, intr=0 next clk.
4. Priority and EOI:
   - MODE=8'hFF, MASK=8'hFF, edges on src[5] and src[1] in the same cycle → VEC=8'h81.
   - Write VEC → PEND=8'h20, VEC=8'h85.
   - Write VEC → PEND=8'h00, intr=0.
5. Collision: W1C PEND=8'h08 in the same cycle as a new src[3] rising edge (MODE[3]=1) → PEND[3] remains 1.
6. Async reset mid-operation: with intr=1 and PEND=8'h10, pulse rst low for less than one clk period between edges → intr and PEND go to 0 immediately without waiting for a clk edge.
